// File: rtl/cpu_trace.sv
// cpu_trace: a non-intrusive instruction/store trace buffer for a small CPU.
// It watches the CPU fetch and write strobes and captures qualifying events
// as timestamped records into a circular FIFO that software drains with pops.
//
// Ports:
//   clk, reset (async, active-low)
//   fetch, halt, wr        CPU phase/strobe inputs
//   pc_addr, ir_addr       CPU program counter and operand address
//   opcode, data           current opcode and data bus value
//   trig_en, mode          trace enable and capture mode (OFF/ALL/OPMATCH/STOREWATCH)
//   match_op, watch_addr   filters for OPMATCH and STOREWATCH modes
//   rd_req                 pop request
//   rd_data, rd_valid      popped record {ts, pc_addr, opcode, ir_addr, data}, valid pulse
//   count, empty, full     FIFO occupancy
//   overflow               sticky flag, set when an event was dropped
//   state                  0 IDLE, 1 ARMED, 2 STOPPED
module cpu_trace #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8,
  parameter int OP_W   = 3,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 fetch,
  input  logic                                 halt,
  input  logic                                 wr,
  input  logic [ADDR_W-1:0]                    pc_addr,
  input  logic [ADDR_W-1:0]                    ir_addr,
  input  logic [OP_W-1:0]                      opcode,
  input  logic [DATA_W-1:0]                    data,
  input  logic                                 trig_en,
  input  logic [1:0]                           mode,
  input  logic [OP_W-1:0]                      match_op,
  input  logic [ADDR_W-1:0]                    watch_addr,
  input  logic                                 rd_req,
  output logic [TS_W+2*ADDR_W+OP_W+DATA_W-1:0] rd_data,
  output logic                                 rd_valid,
  output logic [$clog2(DEPTH):0]               count,
  output logic                                 empty,
  output logic                                 full,
  output logic                                 overflow,
  output logic [1:0]                           state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int REC_W = TS_W + 2*ADDR_W + OP_W + DATA_W;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    STOPPED = 2'd2
  } state_t;

  state_t           cur_state;
  logic             fetch_q;
  logic             wr_q;
  logic [TS_W-1:0]  ts;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [REC_W-1:0] mem [DEPTH];

  logic fetch_rise;
  logic wr_rise;
  logic qualify;
  logic event_hit;
  logic pop;
  logic push;
  logic arm;

  assign state = cur_state;
  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);

  // Event qualification. A full FIFO still accepts an event when a pop
  // frees a slot in the same cycle, so push looks at pop rather than full alone.
  always_comb begin
    fetch_rise = fetch & ~fetch_q;
    wr_rise    = wr & ~wr_q;
    qualify    = 1'b0;
    case (mode)
      2'd1:    qualify = fetch_rise;
      2'd2:    qualify = fetch_rise && (opcode == match_op);
      2'd3:    qualify = wr_rise && (ir_addr == watch_addr);
      default: qualify = 1'b0;
    endcase
    event_hit = (cur_state == ARMED) && qualify;
    pop       = rd_req && !empty;
    push      = event_hit && (!full || pop);
    arm       = (cur_state == IDLE) && trig_en;
  end

  // Control state: FSM, edge detectors, timestamp, pointers and read port.
  // Arming starts a fresh capture session, so it wipes occupancy, the
  // overflow flag and the timestamp; FIFO contents are otherwise kept
  // across IDLE/STOPPED so they can still be drained.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_state <= IDLE;
      fetch_q   <= 1'b0;
      wr_q      <= 1'b0;
      ts        <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      fetch_q  <= fetch;
      wr_q     <= wr;
      rd_valid <= pop;
      if (pop) begin
        rd_data <= mem[rd_ptr];
      end

      if (arm) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        overflow <= 1'b0;
        ts       <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        if (push && !pop) begin
          count <= count + CNT_W'(1);
        end else if (!push && pop) begin
          count <= count - CNT_W'(1);
        end
        if (event_hit && !push) begin
          overflow <= 1'b1;
        end
        if (cur_state == ARMED) begin
          ts <= ts + TS_W'(1);
        end
      end

      // Dropping trig_en always wins; a halt seen while armed freezes capture
      // after this cycle's event (if any) has already been pushed above.
      case (cur_state)
        IDLE: begin
          if (trig_en) begin
            cur_state <= ARMED;
          end
        end
        ARMED: begin
          if (!trig_en) begin
            cur_state <= IDLE;
          end else if (halt) begin
            cur_state <= STOPPED;
          end
        end
        STOPPED: begin
          if (!trig_en) begin
            cur_state <= IDLE;
          end
        end
        default: cur_state <= IDLE;
      endcase
    end
  end

  // Record storage; needs no reset because occupancy lives in count/pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {ts, pc_addr, opcode, ir_addr, data};
    end
  end

endmodule

// File: doc/cpu_trace.md
CPU_TRACE -- requirements
Module: cpu_trace

Interface
REQ-001 SHALL have parameters: ADDR_W, default 13, CPU address width; DATA_W, default 8, data bus width; OP_W, default 3, opcode width; DEPTH, default 16, trace FIFO entries (power of 2, >=2); TS_W, default 16, timestamp width.
REQ-002 SHALL have ports:
- clk  in  1  system clock; all state rising-edge.
- reset  in  1  asynchronous, active-low reset.
- fetch  in  1  CPU fetch phase.
- halt  in  1  CPU halt.
- wr  in  1  CPU memory write strobe.
- pc_addr  in  ADDR_W  CPU program counter.
- ir_addr  in  ADDR_W  instruction operand address.
- opcode  in  OP_W  current opcode.
- data  in  DATA_W  CPU data bus value.
- trig_en  in  1  trace enable.
- mode  in  2  0 OFF, 1 ALL, 2 OPMATCH, 3 STOREWATCH.
- match_op  in  OP_W  opcode filter for mode 2.
- watch_addr  in  ADDR_W  address filter for mode 3.
- rd_req  in  1  pop request.
- rd_data  out  TS_W+2*ADDR_W+OP_W+DATA_W  record {ts, pc_addr, opcode, ir_addr, data}.
- rd_valid  out  1  rd_data valid, one-cycle pulse.
- count  out  $clog2(DEPTH)+1  entries held.
- empty, full  out  1  FIFO flags.
- overflow  out  1  sticky: event dropped.
- state  out  2  0 IDLE, 1 ARMED, 2 STOPPED.

Function
REQ-003 SHALL register fetch and wr each cycle; fetch_rise = fetch & ~fetch_q; wr_rise = wr & ~wr_q.
REQ-004 SHALL qualify an event only in ARMED: mode 1 on fetch_rise; mode 2 on fetch_rise with opcode==match_op; mode 3 on wr_rise with ir_addr==watch_addr; mode 0 never.
REQ-005 SHALL capture the record from input values in the same cycle as the qualifying edge, with ts = timestamp counter value in that cycle.
REQ-006 SHALL increment the timestamp every cycle in ARMED, wrapping from 2^TS_W-1 to 0, and hold it in IDLE and STOPPED.
REQ-007 SHALL implement FSM: IDLE->ARMED when trig_en=1; ARMED->STOPPED when halt=1; ARMED or STOPPED->IDLE when trig_en=0; STOPPED exits only to IDLE.
REQ-008 SHALL, on the IDLE->ARMED transition, clear FIFO pointers, count, overflow, and timestamp to 0.
REQ-009 SHALL still capture an event qualified in the same cycle that halt first asserts, before entering STOPPED.
REQ-010 SHALL, on rd_req with empty=0, pop the oldest record, driving rd_data with rd_valid=1 on the next cycle; rd_data holds its value otherwise.
REQ-011 SHALL ignore rd_req when empty=1, leaving rd_valid=0 and pointers and count unchanged.
REQ-012 SHALL permit pops in any state, including IDLE and STOPPED.
REQ-013 SHALL, on an event when full=1 and no same-cycle pop, drop the event and set overflow=1.
REQ-014 SHALL, on an event and a pop in the same cycle, accept both even when full, leaving count unchanged.
REQ-015 SHALL wrap FIFO pointers modulo DEPTH; empty = (count==0); full = (count==DEPTH).

Reset
REQ-016 SHALL, on reset=0 asynchronously: state=IDLE; count=0; empty=1; full=0; overflow=0; rd_valid=0; rd_data=0; timestamp=0; fetch_q=0; wr_q=0.
REQ-017 SHALL, when reset asserts mid-capture, discard all FIFO contents; after release the block resumes in IDLE.

Verification
REQ-018 SHALL cover mode 1 with 3 fetch pulses at ts 2, 10, 18 and pc 0x000, 0x002, 0x004 -> count=3; pops return the records in order, each with rd_valid one cycle after rd_req.
REQ-019 SHALL cover mode 2 with match_op=3'h5 and opcodes 5, 2, 5, 7 -> exactly 2 records, both opcode 5.
REQ-020 SHALL cover mode 3 with watch_addr=0x00A, writes to 0x00A with data 0x3C and to 0x00B -> 1 record with ir_addr=0x00A, data=0x3C.
REQ-021 SHALL cover DEPTH=16 with 17 events and no pops -> full=1, count=16, overflow=1; then an event plus a pop in the same cycle -> count stays 16.
REQ-022 SHALL cover halt asserted with fetch_rise in the same cycle -> that record is captured, state=2, later fetches ignored; trig_en 0 then 1 -> count=0, overflow=0.
REQ-023 SHALL cover reset pulsed low for 30 ns mid-capture with count=5 -> count=0, empty=1, state=0 immediately, without waiting for a clk edge.
